brch_ckpt_queue: RTL and testbench
==================================

Name: brch_ckpt_queue

Overview:
Parametrised branch checkpoint queue for the dispatch stage. Each in-flight branch gets one entry holding its branch index and the pointer position of its fetch group. The queue supplies the flush position on a misprediction and retires entries when branches commit. It generalises the fixed 4-lane / 2-entry scheme to N lanes and a power-of-two depth, and adds occupancy tracking, backpressure, CAM-based mispredict lookup with younger-entry truncation, and error flagging.

Parameters:
LANES, 4, instructions per dispatch group (1..8)
DEPTH, 4, checkpoint entries; power of two, >= 2
IDX_W, 6, branch index width
POS_W, 7, pointer position width
CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
grp_vld  in  1  dispatch group valid this cycle
lane_brch  in  LANES  lane k holds a branch
lane_need  in  LANES  lane k consumes a pointer slot (pr_need_inst)
base_idx  in  IDX_W  branch index assigned to lane 0
base_pos  in  POS_W  pointer position at lane 0
grp_rdy  out  1  queue can accept the whole current group
mis_pred  in  1  misprediction reported
brch_mis_indx  in  IDX_W  index of the mispredicted branch
cmt_brch  in  1  branch commit
cmt_brch_indx  in  IDX_W  index of the committing branch
flush  out  1  flush request (combinational)
flush_pos  out  POS_W  pointer position to restore
all_nop  out  1  force NOPs into the pipeline (= mis_pred)
count  out  CNT_W  valid entries
empty  out  1  count == 0
full  out  1  count == DEPTH
err  out  1  sticky protocol error

Behaviour:
- Reset (async): head = tail = 0 (each is $clog2(DEPTH) bits plus a wrap bit); all valid bits cleared; entry payloads cleared to 0; err = 0. Combinational outputs follow from that state: count = 0, empty = 1, full = 0, grp_rdy = 1 (when no branch in group), flush = 0, flush_pos = 0.
- Entry format is {idx[IDX_W], pos[POS_W]}.
- Lane k branch entry:
  - idx = base_idx + k, mod 2^IDX_W.
  - pos = base_pos + popcount(lane_need[k-1:0]), mod 2^POS_W.
- nb = popcount(lane_brch).
- grp_rdy = (DEPTH - count >= nb) and !mis_pred. The signal is combinational.
- Allocation:
  - Occurs when grp_vld & grp_rdy & nb > 0.
  - Branches are written in lane order, lowest lane at tail, then tail+1, and so on.
  - tail advances by nb at the clock edge.
  - No partial group is ever written.
- Mispredict lookup:
  - CAM on valid entries where idx == brch_mis_indx.
  - On a match, the oldest matching entry (nearest to head) wins.
  - flush = mis_pred, in the same cycle.
  - flush_pos = pos of the matched entry, else 0.
- Mispredict update, at the next edge:
  - tail = matched slot, so the matched entry and all younger entries are invalidated.
  - No match: queue unchanged, err set.
  - Allocation is suppressed in a mispredict cycle.
- Commit:
  - If cmt_brch and the queue is non-empty and the head idx == cmt_brch_indx: head increments and the head entry is invalidated.
  - If empty or the index mismatches: head is unchanged and err is set.
- Simultaneous commit + mispredict:
  - Both apply.
  - If the mispredict matches head, the queue ends empty, with head = tail = old head + 1.
  - Otherwise head is popped and tail is truncated.
- Simultaneous commit + allocation: both apply. count_next = count - 1 + nb, and this is bounded by DEPTH because grp_rdy was checked against the current count.
- Wrap-around: pointers are mod DEPTH with a wrap bit. full when index bits are equal and wrap bits differ; empty when all bits are equal.
- err is cleared only by reset.
- There is no internal state machine beyond the pointer pair. Latency: lookup is 0 cycles; state update is 1 cycle.

Test Plan:
- Reset, then group lane_brch=0101, lane_need=1111, base_idx=10, base_pos=20 → entries {10,20},{12,22}; count=2.
- DEPTH=4, count=3, group with nb=2 → grp_rdy=0 and nothing written. Commit head, then re-present the group → accepted; count=4, full=1.
- Entries idx 5,6,7 at pos 30,31,33; mis_pred with brch_mis_indx=6 → same cycle flush=1, flush_pos=31; next cycle count=1 and tail points after idx 5.
- Head idx 5 with cmt_brch_indx=5 and mis_pred idx=5 in the same cycle → flush_pos = head pos; next cycle empty=1.
- Wrap: base_idx=63, lane_brch=0011 → idx 63 and 0; 8 alloc/commit cycles around DEPTH=4 → pointers wrap, full and empty stay correct.
- cmt_brch on an empty queue, and mis_pred with an unknown index → err=1, queue unchanged; rst_n low mid-operation → all state cleared asynchronously and err=0.

Source files
------------

// File: rtl/brch_ckpt_queue_if.sv
// Dispatch, flush and commit bundle for the branch checkpoint queue.
// The queue side is the slave; dispatch/flush/commit logic is the master.
interface brch_ckpt_queue_if #(
  parameter int LANES = 4,
  parameter int DEPTH = 4,
  parameter int IDX_W = 6,
  parameter int POS_W = 7,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  logic             grp_vld;
  logic [LANES-1:0] lane_brch;
  logic [LANES-1:0] lane_need;
  logic [IDX_W-1:0] base_idx;
  logic [POS_W-1:0] base_pos;
  logic             grp_rdy;
  logic             mis_pred;
  logic [IDX_W-1:0] brch_mis_indx;
  logic             cmt_brch;
  logic [IDX_W-1:0] cmt_brch_indx;
  logic             flush;
  logic [POS_W-1:0] flush_pos;
  logic             all_nop;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             err;

  modport master (
    output grp_vld, lane_brch, lane_need,
    output base_idx, base_pos,
    output mis_pred, brch_mis_indx,
    output cmt_brch, cmt_brch_indx,
    input  grp_rdy, flush, flush_pos,
    input  all_nop, count, empty, full, err
  );

  modport slave (
    input  grp_vld, lane_brch, lane_need,
    input  base_idx, base_pos,
    input  mis_pred, brch_mis_indx,
    input  cmt_brch, cmt_brch_indx,
    output grp_rdy, flush, flush_pos,
    output all_nop, count, empty, full, err
  );
endinterface

// File: rtl/brch_ckpt_queue.sv
// Branch checkpoint queue: one {idx,pos} entry per in-flight branch,
// CAM lookup for mispredict flush position, in-order retire on commit.
module brch_ckpt_queue #(
  parameter int LANES = 4,
  parameter int DEPTH = 4,
  parameter int IDX_W = 6,
  parameter int POS_W = 7,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic clk,
  input logic rst_n,
  brch_ckpt_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int PW    = PTR_W + 1;

  typedef logic [PW-1:0]    ptr_t;
  typedef logic [PTR_W-1:0] slot_t;

  ptr_t             head_q, head_d;
  ptr_t             tail_q, tail_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [IDX_W-1:0] idx_q [DEPTH];
  logic [IDX_W-1:0] idx_d [DEPTH];
  logic [POS_W-1:0] pos_q [DEPTH];
  logic [POS_W-1:0] pos_d [DEPTH];
  logic             err_q, err_d;

  ptr_t        occ;
  slot_t       hb, tb;
  logic [31:0] nb, free;
  logic        is_empty, is_full;
  logic        rdy, alloc, cmt_ok;
  logic        hit;
  slot_t       moff, mslot;
  int          rank, need;

  function automatic slot_t at(input slot_t b, input int i);
    return b + slot_t'(i);
  endfunction

  assign hb       = head_q[PTR_W-1:0];
  assign tb       = tail_q[PTR_W-1:0];
  assign occ      = tail_q - head_q;
  assign is_empty = (head_q == tail_q);
  assign is_full  = (hb == tb) &&
                    (head_q[PTR_W] != tail_q[PTR_W]);

  always_comb begin
    nb = '0;
    for (int k = 0; k < LANES; k++)
      nb = nb + 32'(bus.lane_brch[k]);
  end

  assign free  = 32'(DEPTH) - 32'(occ);
  assign rdy   = (free >= nb) && !bus.mis_pred;
  assign alloc = bus.grp_vld && rdy && (nb != '0);

  assign cmt_ok = bus.cmt_brch && !is_empty &&
                  (idx_q[hb] == bus.cmt_brch_indx);

  // Walk from head so the oldest matching entry wins.
  always_comb begin
    hit  = 1'b0;
    moff = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && vld_q[at(hb, i)] &&
          idx_q[at(hb, i)] == bus.brch_mis_indx) begin
        hit  = 1'b1;
        moff = slot_t'(i);
      end
    end
  end

  assign mslot = at(hb, int'(moff));

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    vld_d  = vld_q;
    idx_d  = idx_q;
    pos_d  = pos_q;
    rank   = 0;
    need   = 0;
    err_d  = err_q |
             (bus.cmt_brch & ~cmt_ok) |
             (bus.mis_pred & ~hit);

    if (cmt_ok) begin
      head_d    = head_q + ptr_t'(1);
      vld_d[hb] = 1'b0;
    end

    if (bus.mis_pred && hit) begin
      for (int i = 0; i < DEPTH; i++)
        if (slot_t'(i) >= moff)
          vld_d[at(hb, i)] = 1'b0;
      // Popping the flushed head itself leaves head == tail.
      if (cmt_ok && moff == '0)
        tail_d = head_d;
      else
        tail_d = head_q + ptr_t'(moff);
    end else if (alloc) begin
      tail_d = tail_q + ptr_t'(nb);
      for (int k = 0; k < LANES; k++) begin
        if (bus.lane_brch[k]) begin
          vld_d[at(tb, rank)] = 1'b1;
          idx_d[at(tb, rank)] = bus.base_idx + IDX_W'(k);
          pos_d[at(tb, rank)] = bus.base_pos + POS_W'(need);
          rank = rank + 1;
        end
        need = need + int'(bus.lane_need[k]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      vld_q  <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        idx_q[i] <= '0;
        pos_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
      idx_q  <= idx_d;
      pos_q  <= pos_d;
    end
  end

  assign bus.grp_rdy   = rdy;
  assign bus.flush     = bus.mis_pred;
  assign bus.all_nop   = bus.mis_pred;
  assign bus.flush_pos = (bus.mis_pred && hit) ?
                         pos_q[mslot] : '0;
  assign bus.count     = CNT_W'(occ);
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_brch_ckpt_queue.sv
// Bench for brch_ckpt_queue: queue-of-entries reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_brch_ckpt_queue;
  localparam int LANES = 4;
  localparam int DEPTH = 4;
  localparam int IDX_W = 6;
  localparam int POS_W = 7;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  brch_ckpt_queue_if #(
    .LANES(LANES), .DEPTH(DEPTH), .IDX_W(IDX_W),
    .POS_W(POS_W), .CNT_W(CNT_W)
  ) bus ();

  brch_ckpt_queue #(
    .LANES(LANES), .DEPTH(DEPTH), .IDX_W(IDX_W),
    .POS_W(POS_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [POS_W-1:0] pos;
  } ent_t;

  ent_t mq[$];
  bit   merr = 1'b0;
  int   ncmp = 0;
  int   nbad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d want %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int pc(input logic [LANES-1:0] v);
    int n = 0;
    for (int k = 0; k < LANES; k++) n += int'(v[k]);
    return n;
  endfunction

  function automatic int find(input logic [IDX_W-1:0] x);
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].idx == x) return i;
    return -1;
  endfunction

  always @(negedge rst_n) begin
    mq.delete();
    merr = 1'b0;
  end

  // Reference model: branches in flight as an ordered list.
  always @(posedge clk) begin : mdl
    int m;
    int nb;
    int nd;
    bit cok;
    bit rdy;
    if (rst_n) begin
      nb  = pc(bus.lane_brch);
      m   = find(bus.brch_mis_indx);
      rdy = (DEPTH - mq.size() >= nb) && !bus.mis_pred;
      cok = bus.cmt_brch && mq.size() > 0 &&
            mq[0].idx == bus.cmt_brch_indx;
      if (bus.cmt_brch && !cok) merr = 1'b1;
      if (bus.mis_pred) begin
        if (m < 0) merr = 1'b1;
        else while (mq.size() > m) void'(mq.pop_back());
      end
      if (cok && mq.size() > 0) void'(mq.pop_front());
      if (bus.grp_vld && rdy && nb > 0) begin
        nd = 0;
        for (int k = 0; k < LANES; k++) begin
          if (bus.lane_brch[k])
            mq.push_back('{idx: bus.base_idx + IDX_W'(k),
                           pos: bus.base_pos + POS_W'(nd)});
          nd += int'(bus.lane_need[k]);
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    int nb;
    int m;
    logic [POS_W-1:0] fp;
    #2;
    nb = pc(bus.lane_brch);
    m  = find(bus.brch_mis_indx);
    fp = '0;
    if (bus.mis_pred && m >= 0) fp = mq[m].pos;
    chk("count", bus.count, mq.size());
    chk("empty", bus.empty, mq.size() == 0);
    chk("full", bus.full, mq.size() == DEPTH);
    chk("grp_rdy", bus.grp_rdy,
        (DEPTH - mq.size() >= nb) && !bus.mis_pred);
    chk("flush", bus.flush, bus.mis_pred);
    chk("all_nop", bus.all_nop, bus.mis_pred);
    chk("flush_pos", bus.flush_pos, fp);
    chk("err", bus.err, merr);
  end

  task automatic drv(input bit v,
                     input logic [3:0] b,
                     input logic [3:0] n,
                     input int bi, input int bp,
                     input bit mp, input int mi,
                     input bit cm, input int ci);
    @(negedge clk);
    bus.grp_vld       = v;
    bus.lane_brch     = b;
    bus.lane_need     = n;
    bus.base_idx      = IDX_W'(bi);
    bus.base_pos      = POS_W'(bp);
    bus.mis_pred      = mp;
    bus.brch_mis_indx = IDX_W'(mi);
    bus.cmt_brch      = cm;
    bus.cmt_brch_indx = IDX_W'(ci);
    #3;
  endtask

  task automatic idle();
    drv(0, 4'b0, 4'b0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cmt(input int ci);
    drv(0, 4'b0, 4'b0, 0, 0, 0, 0, 1, ci);
  endtask

  task automatic mp(input int mi);
    drv(0, 4'b0, 4'b0, 0, 0, 1, mi, 0, 0);
  endtask

  initial begin
    bus.grp_vld       = 1'b0;
    bus.lane_brch     = '0;
    bus.lane_need     = '0;
    bus.base_idx      = '0;
    bus.base_pos      = '0;
    bus.mis_pred      = 1'b0;
    bus.brch_mis_indx = '0;
    bus.cmt_brch      = 1'b0;
    bus.cmt_brch_indx = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_rdy", bus.grp_rdy, 1);
    chk("rst_fpos", bus.flush_pos, 0);
    chk("rst_err", bus.err, 0);

    // Lanes 0 and 2: {10,20} and {12,22}
    drv(1, 4'b0101, 4'b1111, 10, 20, 0, 0, 0, 0);
    chk("g1_rdy", bus.grp_rdy, 1);
    idle();
    chk("g1_count", bus.count, 2);
    mp(12);
    chk("g1_flush", bus.flush, 1);
    chk("g1_fpos", bus.flush_pos, 22);
    idle();
    chk("g1_trunc", bus.count, 1);
    cmt(10);
    idle();
    chk("g1_empty", bus.empty, 1);

    // Backpressure at count 3 with a two-branch group
    drv(1, 4'b0111, 4'b0000, 1, 40, 0, 0, 0, 0);
    idle();
    chk("bp_count3", bus.count, 3);
    drv(1, 4'b0011, 4'b0000, 4, 50, 0, 0, 0, 0);
    chk("bp_rdy0", bus.grp_rdy, 0);
    drv(1, 4'b0011, 4'b0000, 4, 50, 0, 0, 0, 0);
    chk("bp_hold", bus.count, 3);
    cmt(1);
    drv(1, 4'b0011, 4'b0000, 4, 50, 0, 0, 0, 0);
    chk("bp_rdy1", bus.grp_rdy, 1);
    idle();
    chk("bp_count4", bus.count, 4);
    chk("bp_full", bus.full, 1);
    drv(1, 4'b0001, 4'b0000, 9, 9, 0, 0, 0, 0);
    chk("bp_full_rdy", bus.grp_rdy, 0);
    cmt(2);
    cmt(3);
    cmt(4);
    cmt(5);
    idle();
    chk("bp_drain", bus.empty, 1);

    // idx 5,6,7 at pos 30,31,33; flush on 6
    drv(1, 4'b0011, 4'b0001, 5, 30, 0, 0, 0, 0);
    drv(1, 4'b0001, 4'b0000, 7, 33, 0, 0, 0, 0);
    mp(6);
    chk("mp_flush", bus.flush, 1);
    chk("mp_fpos", bus.flush_pos, 31);
    idle();
    chk("mp_count", bus.count, 1);
    cmt(5);
    idle();
    chk("mp_empty", bus.empty, 1);
    chk("mp_err", bus.err, 0);

    // Commit and mispredict on the head in one cycle
    drv(1, 4'b0011, 4'b0001, 5, 30, 0, 0, 0, 0);
    drv(0, 4'b0, 4'b0, 0, 0, 1, 5, 1, 5);
    chk("cm_fpos", bus.flush_pos, 30);
    idle();
    chk("cm_empty", bus.empty, 1);
    chk("cm_count", bus.count, 0);

    // Index wrap 63 -> 0, then pointers lap the ring
    drv(1, 4'b0011, 4'b1111, 63, 120, 0, 0, 0, 0);
    idle();
    chk("wr_count", bus.count, 2);
    for (int i = 0; i < 8; i++) begin
      drv(1, 4'b0001, 4'b0000, 20 + i, i, 0, 0, 1,
          (i == 0) ? 63 : (i == 1) ? 0 : 18 + i);
    end
    idle();
    chk("wr_steady", bus.count, 2);
    drv(1, 4'b0011, 4'b0000, 30, 0, 0, 0, 0, 0);
    idle();
    chk("wr_full", bus.full, 1);
    mp(30);
    chk("wr_fpos", bus.flush_pos, 0);
    cmt(26);
    cmt(27);
    idle();
    chk("wr_empty", bus.empty, 1);
    chk("wr_err", bus.err, 0);

    // Unknown mispredict index flags err, queue unchanged
    drv(1, 4'b0001, 4'b0000, 40, 7, 0, 0, 0, 0);
    mp(41);
    chk("uk_fpos", bus.flush_pos, 0);
    idle();
    chk("uk_err", bus.err, 1);
    chk("uk_count", bus.count, 1);

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_count", bus.count, 0);
    chk("ar_err", bus.err, 0);
    chk("ar_empty", bus.empty, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Commit on an empty queue
    cmt(3);
    idle();
    chk("ce_err", bus.err, 1);
    chk("ce_count", bus.count, 0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end
endmodule
